fp_accumulator: RTL
===================

Name: fp_accumulator

Overview:
- Sequential front end for the combinational single-precision FPAdder; sits directly upstream of it and also consumes its result.
- Accepts a stream of IEEE-754 binary32 operands over a valid/ready handshake.
- Drives the adder with (running sum, new operand) and registers the adder's sum each cycle.
- After N_TERMS operands, or an early in_last, presents the total on a valid/ready output.

Parameters:
- N_TERMS, 8, operands per accumulation; legal range 1..2^CNT_W-1.
- CNT_W, 4, width of the term counter and of out_count.

Ports:
- clk        input   1       system clock, rising edge.
- rst        input   1       asynchronous, active-high reset.
- in_valid   input   1       in_data holds an operand.
- in_ready   output  1       block can accept an operand this cycle.
- in_data    input   32      binary32 operand.
- in_last    input   1       qualified by in_valid; marks the final operand of the current group.
- add_a      output  32      adder operand A; equals acc_q, combinational from the register.
- add_b      output  32      adder operand B; equals in_data, combinational pass-through.
- add_sum    input   32      adder result, combinational, same cycle.
- out_valid  output  1       out_data and out_count are valid.
- out_ready  input   1       downstream accepts the result.
- out_data   output  32      accumulated binary32 sum.
- out_count  output  CNT_W   number of operands summed into out_data.

Behaviour:
- Reset (async, immediate): state=ACC, acc_q=0x00000000, cnt_q=0, out_valid=0. in_ready is 1 after reset is released.
- States:
  - ACC: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accept in ACC occurs when in_valid && in_ready at a rising clk edge.
  - cnt_q==0: acc_q<=in_data verbatim. The adder is bypassed, so a first term of -0, denormal, Inf or NaN is kept bit-exact.
  - cnt_q!=0: acc_q<=add_sum.
  - In both cases cnt_q<=cnt_q+1.
- ACC->DONE on the accepting edge when cnt_q+1==N_TERMS or in_last==1. The new acc_q and cnt_q are visible with out_valid in the next cycle.
- Latency: the last operand is accepted at edge k; out_valid=1 in the cycle after edge k (1 cycle).
- In DONE: out_data=acc_q and out_count=cnt_q, both held stable until the transfer completes.
- DONE->ACC on out_valid && out_ready. That edge also sets cnt_q<=0 and acc_q<=0. in_ready returns to 1 in the next cycle, so there is no same-cycle input/output overlap.
- out_ready low: out_valid, out_data and out_count are held indefinitely; no input is accepted.
- in_valid low in ACC: no state change; partial sum and count are retained.
- in_last with N_TERMS reached on the same beat: a single transition to DONE with count N_TERMS; no double counting.
- No rounding or exception logic lives here; arithmetic behaviour (rounding, denormals, Inf/NaN) is entirely that of the adder.
- Reset mid-accumulation or while in DONE discards the partial or pending result. out_valid drops immediately (asynchronous).
- cnt_q never exceeds N_TERMS; no wrap-around is possible.

Test Plan:
- N_TERMS=8: eight beats of 0x3F800000 (1.0), in_valid held high -> out_valid one cycle after the 8th edge; out_data=0x41000000 (8.0), out_count=8.
- Two beats 0x42C88000 (100.25) then 0x3F9E6000 (1.2373046875) with in_last on beat 2 -> out_data=0x42CAF980, out_count=2; in_ready=0 while out_valid=1.
- Single beat 0x80000000 with in_last -> out_data=0x80000000 exactly (bypass), out_count=1.
- Backpressure: complete a group with out_ready=0 for 5 cycles -> out_valid stays 1, out_data stable, in_ready stays 0. Then raise out_ready -> out_valid falls next cycle, in_ready returns to 1, and the next group starts from count 0.
- Gaps: 0x3F800000, idle 3 cycles, 0x3F800000 with in_last -> out_data=0x40000000, out_count=2.
- Reset: assert rst after 3 accepted terms (between clock edges) -> out_valid=0 and internal count=0 immediately. After release, one beat 0x40400000 with in_last -> out_data=0x40400000, out_count=1.

Source files
------------

// File: rtl/fp_accumulator.sv
// Sequential front end for a combinational binary32 adder: sums N_TERMS operands
// (or fewer when in_last) and presents the total one cycle after the last accept.
module fp_accumulator #(
  parameter int N_TERMS = 8,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  input  logic [31:0]      add_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic {ACC, DONE} state_t;

  // Counter value of the accepting beat that completes a full group.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

  state_t           state;
  logic [31:0]      acc_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACC;
      acc_q <= 32'h0000_0000;
      cnt_q <= '0;
    end else begin
      case (state)
        ACC: begin
          if (in_valid) begin
            // First term bypasses the adder so -0, denormals, Inf and NaN survive bit-exact.
            acc_q <= (cnt_q == '0) ? in_data : add_sum;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_CNT || in_last)
              state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= ACC;
            acc_q <= 32'h0000_0000;
            cnt_q <= '0;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

  assign in_ready  = (state == ACC);
  assign out_valid = (state == DONE);
  assign add_a     = acc_q;
  assign add_b     = in_data;
  assign out_data  = acc_q;
  assign out_count = cnt_q;

endmodule
